// File: rtl/lc2k_fetch.sv
// LC-2K instruction-fetch stage: owns the PC, reads combinational instruction memory,
// and fills the IF/ID register. It also handles stall, redirect/flush, halt and out-of-range faults.
module lc2k_fetch #(
  parameter logic [31:0] RESET_PC   = '0,
  parameter int unsigned IMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc_out,
  input  logic [31:0] instr_in,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus1,
  output logic        halted,
  output logic        pc_fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         valid_d;
  logic         capture;
  logic         is_halt;
  logic         in_range;

  assign is_halt  = (instr_in[24:22] == 3'b110);
  assign in_range = (pc_q < 32'(IMEM_DEPTH));

  // Halt and fault are mutually exclusive: either state blocks the fetch that could set the other.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = if_id_valid;
    capture = 1'b0;
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      valid_d = 1'b0;
      state_d = RUN;
    end else if (stall) begin
      valid_d = if_id_valid;
    end else if (state_q != RUN) begin
      valid_d = 1'b0;
    end else if (!in_range) begin
      state_d = FAULT;
      valid_d = 1'b0;
    end else begin
      capture = 1'b1;
      valid_d = 1'b1;
      if (is_halt) state_d = HALT;
      else         pc_d    = pc_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      pc_q           <= RESET_PC;
      if_id_valid    <= 1'b0;
      if_id_instr    <= '0;
      if_id_pc       <= '0;
      if_id_pc_plus1 <= '0;
      fetch_count    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      if_id_valid <= valid_d;
      if (capture) begin
        if_id_instr    <= instr_in;
        if_id_pc       <= pc_q;
        if_id_pc_plus1 <= pc_q + 32'd1;
        fetch_count    <= fetch_count + 32'd1;
      end
    end
  end

  assign pc_out   = pc_q;
  assign halted   = (state_q == HALT);
  assign pc_fault = (state_q == FAULT);

endmodule
